// File: rtl/div_32b_by_sub_if.sv
// Request/result bundle between processor control and the multi-cycle divider.
// The master drives the operands and start; the slave (the divider) returns status and results.
interface div_32b_by_sub_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             op_signed;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             result_rdy;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;
  logic             ovf;

  modport master (
    output start, op_signed, dividend, divisor,
    input  busy, result_rdy, quotient, remainder, div_by_zero, ovf
  );

  modport slave (
    input  start, op_signed, dividend, divisor,
    output busy, result_rdy, quotient, remainder, div_by_zero, ovf
  );
endinterface

// File: rtl/div_32b_by_sub.sv
// Restoring divider: one quotient bit per clock by trial subtraction on operand magnitudes,
// with the signs applied in a final FIX cycle. Signed results follow C truncation.
module div_32b_by_sub #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic              clock,
  input  logic              resetn,
  div_32b_by_sub_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST_IT = CNT_W'(WIDTH - 1);

  state_t           state_q;
  logic             sgn_q;
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dsr_q;
  logic [WIDTH-1:0] dsr_abs_q;
  logic [WIDTH:0]   p_q;
  logic [WIDTH-1:0] q_q;
  logic             qneg_q;
  logic             rneg_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             rdy_q;
  logic [WIDTH-1:0] quot_q;
  logic [WIDTH-1:0] rem_q;
  logic             dbz_q;
  logic             ovf_q;

  logic [WIDTH:0]   shifted_d;
  logic [WIDTH+1:0] trial_d;
  logic             no_borrow_d;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic sgn);
    return (sgn && x[WIDTH-1]) ? -x : x;
  endfunction

  // Subtract as add-of-inverse with carry-in 1; the carry out of bit WIDTH+1 means no borrow.
  always_comb begin
    shifted_d   = {p_q[WIDTH-1:0], q_q[WIDTH-1]};
    trial_d     = {1'b0, shifted_d} + {1'b0, ~{1'b0, dsr_abs_q}} + (WIDTH+2)'(1);
    no_borrow_d = trial_d[WIDTH+1];
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q   <= IDLE;
      sgn_q     <= 1'b0;
      dvd_q     <= '0;
      dsr_q     <= '0;
      dsr_abs_q <= '0;
      p_q       <= '0;
      q_q       <= '0;
      qneg_q    <= 1'b0;
      rneg_q    <= 1'b0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      rdy_q     <= 1'b0;
      quot_q    <= '0;
      rem_q     <= '0;
      dbz_q     <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          rdy_q <= 1'b0;
          if (bus.start) begin
            sgn_q     <= bus.op_signed;
            dvd_q     <= bus.dividend;
            dsr_q     <= bus.divisor;
            dsr_abs_q <= mag(bus.divisor, bus.op_signed);
            p_q       <= '0;
            q_q       <= mag(bus.dividend, bus.op_signed);
            qneg_q    <= bus.op_signed & (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
            rneg_q    <= bus.op_signed & bus.dividend[WIDTH-1];
            cnt_q     <= '0;
            dbz_q     <= 1'b0;
            ovf_q     <= 1'b0;
            // A zero divisor skips CALC and passes through FIX without raising busy.
            if (bus.divisor == '0) begin
              state_q <= FIX;
              busy_q  <= 1'b0;
            end else begin
              state_q <= CALC;
              busy_q  <= 1'b1;
            end
          end
        end
        CALC: begin
          if (no_borrow_d) begin
            p_q <= trial_d[WIDTH:0];
            q_q <= {q_q[WIDTH-2:0], 1'b1};
          end else begin
            p_q <= shifted_d;
            q_q <= {q_q[WIDTH-2:0], 1'b0};
          end
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST_IT) begin
            state_q <= FIX;
          end
        end
        FIX: begin
          busy_q  <= 1'b0;
          rdy_q   <= 1'b1;
          state_q <= DONE;
          if (dsr_q == '0) begin
            quot_q <= '1;
            rem_q  <= dvd_q;
            dbz_q  <= 1'b1;
            ovf_q  <= 1'b0;
          end else begin
            quot_q <= qneg_q ? -q_q : q_q;
            rem_q  <= rneg_q ? -p_q[WIDTH-1:0] : p_q[WIDTH-1:0];
            dbz_q  <= 1'b0;
            ovf_q  <= sgn_q & (dvd_q == MIN_NEG) & (dsr_q == '1);
          end
        end
        DONE: begin
          rdy_q   <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          rdy_q   <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.result_rdy  = rdy_q;
  assign bus.quotient    = quot_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.ovf         = ovf_q;

endmodule
